// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester memory arbiter (fetch + data) onto a single
// memory port with exactly one transaction outstanding at a time.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   if_req/if_addr               fetch request (read-only)
//   if_gnt/if_rvalid/if_rdata    fetch grant and response
//   d_req/d_we/d_addr/d_wdata/d_be   data request
//   d_gnt/d_rvalid/d_rdata       data grant and response
//   m_req/m_we/m_addr/m_wdata/m_be   memory request (combinational in IDLE)
//   m_gnt/m_rvalid/m_rdata       memory grant and response
//   err_spurious                 sticky: m_rvalid with nothing outstanding
//
// Build option: define ARB_STARVE_GUARD_EN to add the fetch starvation guard.
// Without it, data always wins when both requesters ask.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no transaction outstanding; arbitrate and forward request
// WAIT  | one transaction granted; waiting for m_rvalid to return it
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        err_spurious
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic   sel_fetch;
  logic   starve_fire;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("mem_arbiter: STARVE_LIMIT must be within 1..15");
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_FETCH;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    sel_fetch = if_req & (~d_req | starve_fire);
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = 32'h0;
    m_wdata   = 32'h0;
    m_be      = 4'h0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = 32'h0;
    d_rdata   = 32'h0;
    case (state_q)
      S_IDLE: begin
        m_req = if_req | d_req;
        if (sel_fetch) begin
          m_addr = if_addr;
          m_be   = 4'hf;
        end else begin
          m_we    = d_we;
          m_addr  = d_addr;
          m_wdata = d_wdata;
          m_be    = d_be;
        end
        if (m_req && m_gnt) begin
          if_gnt  = sel_fetch;
          d_gnt   = ~sel_fetch;
          state_d = S_WAIT;
          owner_d = sel_fetch ? OWN_FETCH : OWN_DATA;
        end
      end
      S_WAIT: begin
        // Completion frees the port for the next cycle only; no same-cycle
        // re-grant keeps grants at least two cycles apart.
        if (m_rvalid) begin
          if (owner_q == OWN_FETCH) begin
            if_rvalid = 1'b1;
            if_rdata  = m_rdata;
          end else begin
            d_rvalid = 1'b1;
            d_rdata  = m_rdata;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Async reset also silences the combinational request path.
    if (!reset_n) begin
      m_req     = 1'b0;
      m_we      = 1'b0;
      m_addr    = 32'h0;
      m_wdata   = 32'h0;
      m_be      = 4'h0;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      if_rdata  = 32'h0;
      d_rdata   = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_spurious <= 1'b0;
    else if (state_q == S_IDLE && m_rvalid)
      err_spurious <= 1'b1;
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      starve_cnt <= 4'd0;
    else if (if_gnt)
      starve_cnt <= 4'd0;
    else if (d_gnt && if_req && starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 4'd1;
  end

  assign starve_fire = (starve_cnt == LIMIT);
`else
  assign starve_fire = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_gnt, m_rvalid;
  logic [31:0] m_rdata;
  logic        err_spurious;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    // Requests active during reset must not produce grants.
    if_req = 1'b1; if_addr = 32'h40; m_gnt = 1'b1; m_rvalid = 1'b1;
    #1;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    @(negedge clk);
    chk("rst_err", err_spurious, 0);
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Fetch only
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40; m_gnt = 1'b1;
    #1;
    chk("f_if_gnt", if_gnt, 1);
    chk("f_d_gnt", d_gnt, 0);
    chk("f_m_addr", m_addr, 32'h40);
    chk("f_m_we", m_we, 0);
    chk("f_m_be", m_be, 4'hf);
    @(negedge clk);
    if_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00500093;
    #1;
    chk("f_wait_m_req", m_req, 0);
    chk("f_if_rvalid", if_rvalid, 1);
    chk("f_if_rdata", if_rdata, 32'h00500093);
    chk("f_d_rvalid", d_rvalid, 0);
    chk("f_d_rdata", d_rdata, 0);
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    chk("f_if_rvalid_off", if_rvalid, 0);
    chk("f_if_rdata_off", if_rdata, 0);
    chk("f_err", err_spurious, 0);

    // Simultaneous: data wins, fetch follows
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    d_be = 4'b0011; m_gnt = 1'b1;
    #1;
    chk("s_d_gnt", d_gnt, 1);
    chk("s_if_gnt", if_gnt, 0);
    chk("s_m_we", m_we, 1);
    chk("s_m_be", m_be, 4'b0011);
    chk("s_m_addr", m_addr, 32'h100);
    chk("s_m_wdata", m_wdata, 32'hDEADBEEF);
    @(negedge clk);
    d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0;
    #1;
    chk("s_d_rvalid", d_rvalid, 1);
    chk("s_no_regrant", if_gnt, 0);
    chk("s_wait_m_req", m_req, 0);
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    chk("s_if_gnt_next", if_gnt, 1);
    chk("s_f_m_addr", m_addr, 32'h44);
    chk("s_f_m_we", m_we, 0);
    chk("s_f_m_be", m_be, 4'hf);
    @(negedge clk);
    if_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D;
    #1;
    chk("s_if_rvalid", if_rvalid, 1);
    chk("s_if_rdata", if_rdata, 32'hCAFEF00D);
    @(negedge clk);
    m_rvalid = 1'b0;

    // Backpressure
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h48;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hf; m_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_d_gnt", d_gnt, 0);
      chk("bp_if_gnt", if_gnt, 0);
      chk("bp_m_req", m_req, 1);
      chk("bp_m_addr", m_addr, 32'h200);
      @(negedge clk);
    end
    m_gnt = 1'b1;
    #1;
    chk("bp_d_gnt_c4", d_gnt, 1);
    chk("bp_if_gnt_c4", if_gnt, 0);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h12345678;
    #1;
    chk("bp_d_rvalid", d_rvalid, 1);
    chk("bp_d_rdata", d_rdata, 32'h12345678);
    chk("bp_if_rvalid", if_rvalid, 0);
    @(negedge clk);
    m_rvalid = 1'b0;

    // Reset mid-WAIT abandons the transaction
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h300; m_gnt = 1'b1;
    #1;
    chk("rw_d_gnt", d_gnt, 1);
    @(negedge clk);
    d_req = 1'b0; m_gnt = 1'b0; reset_n = 1'b0;
    #1;
    chk("rw_rst_m_req", m_req, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rw_err_pre", err_spurious, 0);
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'hAAAA5555;
    #1;
    chk("rw_d_rvalid", d_rvalid, 0);
    chk("rw_d_rdata", d_rdata, 0);
    chk("rw_if_rvalid", if_rvalid, 0);
    chk("rw_err_same", err_spurious, 0);
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    chk("rw_err_set", err_spurious, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("rw_err_sticky", err_spurious, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rw_err_clear", err_spurious, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Spurious response with nothing requested
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'h55AA55AA;
    #1;
    chk("sp_if_rvalid", if_rvalid, 0);
    chk("sp_d_rvalid", d_rvalid, 0);
    chk("sp_err_same", err_spurious, 0);
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    chk("sp_err_next", err_spurious, 1);
    reset_pulse();

    // Starvation: both held, response one cycle after each grant.
    // Guard on (limit 4): D D D D F D.  Guard off: data every time.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h60;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_be = 4'hf;
    for (int k = 0; k < 6; k++) begin
      logic exp_f;
      exp_f = GUARD && (k == 4);
      m_gnt = 1'b1; m_rvalid = 1'b0;
      #1;
      chk($sformatf("st_if_gnt_%0d", k), if_gnt, exp_f);
      chk($sformatf("st_d_gnt_%0d", k), d_gnt, !exp_f);
      @(negedge clk);
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1000 + k;
      #1;
      chk($sformatf("st_if_rvalid_%0d", k), if_rvalid, exp_f);
      chk($sformatf("st_d_rvalid_%0d", k), d_rvalid, !exp_f);
      @(negedge clk);
    end
    idle_inputs();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, range 1-15: consecutive data grants tolerated while fetch waits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have fetch ports if_req in 1, if_addr in 32, if_gnt out 1, if_rvalid out 1, if_rdata out 32 (read-only requester).
REQ-005 SHALL have data ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32, d_be in 4, d_gnt out 1, d_rvalid out 1, d_rdata out 32.
REQ-006 SHALL have memory ports m_req out 1, m_we out 1, m_addr out 32, m_wdata out 32, m_be out 4, m_gnt in 1, m_rvalid in 1, m_rdata in 32.
REQ-007 SHALL have port err_spurious  output  1  sticky flag: m_rvalid seen with no transaction outstanding.

Function
REQ-008 SHALL implement FSM states IDLE and WAIT, plus an owner register (FETCH/DATA).
REQ-009 In IDLE, m_req SHALL equal if_req | d_req; m_we/m_addr/m_wdata/m_be SHALL be driven combinationally from the selected requester.
REQ-010 Selection: only one requesting -> that one; both requesting -> DATA, except FETCH when starvation guard fires (REQ-020).
REQ-011 When fetch is selected, m_we SHALL be 0 and m_be SHALL be 4'b1111.
REQ-012 Grant (IDLE & m_req & m_gnt) SHALL assert exactly the selected requester's gnt in the same cycle; the other gnt SHALL be 0.
REQ-013 On grant, FSM SHALL move IDLE->WAIT and latch owner; without m_gnt it SHALL stay IDLE and re-arbitrate next cycle.
REQ-014 In WAIT, m_req, if_gnt and d_gnt SHALL be 0; exactly one transaction outstanding.
REQ-015 In WAIT with m_rvalid=1: owner's rvalid SHALL be 1 that cycle, owner's rdata = m_rdata, FSM -> IDLE; no new grant in that cycle (min 2 cycles between grants).
REQ-016 Writes SHALL also complete via m_rvalid; rdata is passed through and ignored by requester.
REQ-017 if_rdata/d_rdata SHALL be m_rdata when their rvalid is 1 and 32'h0 otherwise.
REQ-018 m_rvalid in IDLE SHALL be dropped (no rvalid out) and SHALL set err_spurious, held until reset.
REQ-019 Requesters SHALL hold req and fields stable until gnt; arbiter does not register request fields.

Configuration
REQ-020 With ARB_STARVE_GUARD_EN defined: 4-bit counter increments on each data grant while if_req=1, saturates at STARVE_LIMIT, clears on fetch grant; when counter==STARVE_LIMIT and both request, FETCH SHALL win.
REQ-021 Without ARB_STARVE_GUARD_EN: counter SHALL not exist; strict DATA priority always.

Reset
REQ-022 reset_n low SHALL immediately force IDLE, owner FETCH, counter 0, err_spurious 0.
REQ-023 During reset all outputs SHALL be 0 except as combinationally selected by REQ-009 once reset_n deasserts; gnt/rvalid SHALL be 0 while reset_n=0.
REQ-024 Reset in WAIT SHALL abandon the outstanding transaction; a later m_rvalid for it SHALL be treated per REQ-018.

Verification
REQ-025 Fetch only: if_req=1, if_addr=0x40, m_gnt=1, m_rvalid next cycle with m_rdata=0x00500093 -> if_gnt cycle 0, if_rvalid+if_rdata=0x00500093 cycle 1, d_* idle.
REQ-026 Simultaneous: if_req=d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011 -> d_gnt, m_we=1, m_be=4'b0011, if_gnt=0; fetch granted first IDLE cycle after d_rvalid.
REQ-027 Backpressure: both requesting, m_gnt=0 for 3 cycles -> no gnt, FSM IDLE, m_addr=d_addr; m_gnt=1 on cycle 4 -> d_gnt.
REQ-028 Starvation (guard on, STARVE_LIMIT=4): if_req and d_req held 1, m_rvalid 1 cycle after each grant -> 4 data grants then fetch grant, counter 0; guard off -> data granted indefinitely.
REQ-029 Reset mid-WAIT: grant data, pull reset_n low before m_rvalid, release, then m_rvalid=1 in IDLE -> no d_rvalid, err_spurious=1 until next reset.
REQ-030 Spurious: m_rvalid=1 with no request after reset -> if_rvalid=d_rvalid=0, err_spurious=1 from next cycle.
